video_bitmap_gen: RTL and testbench
===================================

# video_bitmap_gen

Pixel source that sits directly upstream of the composite video DAC stage. It holds a 160x120 1-bpp bitmap that the CPU writes, and walks that bitmap in step with the timing strobes (pixel enable, active-video, vsync). It emits one registered 8-bit luminance value per pixel, which the composite stage maps to black/white DAC levels (values above 0x80 are treated as white). It also reports vblank status and a frame-start pulse to the CPU side.

## Interface
Parameters:
- H_OFFSET, 40: active pixels from line start to the first bitmap pixel.
- FG_LUMA, 8'hFF: luma for a set bitmap bit.
- BG_LUMA, 8'h00: luma for a clear bitmap bit.
- BORDER_LUMA, 8'h00: luma inside active video but outside the bitmap window.

Ports:
- clk, input, 1: single system clock; all logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- pixel_clk_en, input, 1: one-clk pixel strobe; never asserted on two consecutive clks.
- video_active, input, 1: high during visible pixels; qualified by pixel_clk_en.
- vsync_n, input, 1: vertical sync, active low.
- cpu_we, input, 1: write strobe, one byte per clk.
- cpu_re, input, 1: read strobe.
- cpu_addr, input, 12: byte address, 0..2399 valid.
- cpu_wdata, input, 8: write data; bit7 is the leftmost pixel.
- cpu_rdata, output, 8: read data, one clk after cpu_re.
- luma, output, 8: pixel luminance to the composite stage.
- in_vblank, output, 1: high while the line counter is at 480 or above, or while vsync_n is low.
- frame_start, output, 1: one-clk pulse on the vsync_n falling edge.

## Operation
- Storage: 2400 x 8 synchronous RAM, organised as 20 bytes per row, 120 rows. Row r, column c is at byte r*20 + (c>>3), bit 7-(c&7). Compute r*20 as (r<<4)+(r<<2); no multiplier.
- Pixel counter x (10 bits):
  - On pixel_clk_en with video_active high: x increments.
  - While video_active is low: x is held at 0.
- Line counter y (10 bits):
  - Increments on the falling edge of video_active, detected against a registered copy of video_active.
  - Cleared to 0 while vsync_n is low.
  - Saturates at 1023.
- Window: x in [H_OFFSET, H_OFFSET+640) and y < 480.
  - Bitmap column = (x-H_OFFSET)>>2; row = y>>2. Each bitmap pixel covers 4x4 screen pixels.
- Fetch pipeline:
  - Stage 0, on pixel_clk_en: compute the RAM address and bit index, register the window flag and active flag.
  - Stage 1: RAM data returns.
  - Stage 2: luma <= FG_LUMA or BG_LUMA from the selected bit if window and active; BORDER_LUMA if active but outside the window; BG_LUMA if not active.
- CPU port:
  - Write with cpu_addr >= 2400: ignored.
  - Read with cpu_addr >= 2400: returns 8'h00.
  - cpu_we and cpu_re in the same clk: the read returns the old data; the write still completes.
  - CPU access never stalls video and needs no handshake.
- Video/CPU collision: a video fetch and a CPU write to the same byte in the same clk return old data to video; the new data is visible from the next clk.
- frame_start: registered edge detect on vsync_n (high then low).

## Timing
- Reset values:
  - luma = BG_LUMA, cpu_rdata = 0, frame_start = 0, in_vblank = 1.
  - x = 0, y = 0, all pipeline flags = 0.
  - RAM contents are not reset.
- Latency:
  - luma reflects the pixel sampled on a pixel_clk_en exactly 2 clks later, then holds until the next update.
  - The downstream stage samples luma on its next pixel_clk_en, so there is a one-pixel shift. The timing block accounts for it; H_OFFSET is not adjusted.
- cpu_rdata is valid exactly 1 clk after cpu_re and holds until the next cpu_re.
- Boundaries:
  - x = H_OFFSET+639 is the last window pixel; x = H_OFFSET+640 gives BORDER_LUMA.
  - y = 479 is the last row; y >= 480 gives BORDER_LUMA and in_vblank = 1.
  - A video_active low pulse of one pixel still increments y by exactly 1.
- Reset asserted mid-line: all outputs take their reset values immediately (asynchronous). After release, luma stays BG_LUMA until the first active pixel completes the 2-clk pipeline.

## Test plan
- Reset: assert mid-frame -> luma = 8'h00, in_vblank = 1, frame_start = 0 during reset; y restarts at 0 after the next vsync_n low.
- CPU write/read: write 8'hA5 to address 0, read address 0 -> cpu_rdata = 8'hA5 one clk after cpu_re. Read address 2400 -> 8'h00. Write to 2400 -> no RAM change.
- Pixel map: byte 0 = 8'h80, rest 0.
  - Line 0: luma = FG for x = 40..43; BG for x = 44..679; BORDER for x < 40 and x >= 680.
  - Lines 1..3: same pattern. Line 4: all BG in the window.
- Last cell: byte 2399 = 8'h01 -> FG only for x = 676..679 on lines 476..479; in_vblank rises when y reaches 480.
- Collision: CPU write 8'hFF to byte 20 in the same clk as the video fetch of byte 20 (previously 0) -> that pixel shows BG; the next fetch of byte 20 shows FG.
- frame_start: vsync_n high->low -> exactly one 1-clk pulse; y = 0 on the first active line after vsync_n returns high.

Source files
------------

// File: rtl/video_bitmap_gen.sv
// video_bitmap_gen: 160x120 1-bpp CPU-written bitmap scanned out as 8-bit luma,
// each bitmap pixel covering a 4x4 block of screen pixels.
module video_bitmap_gen #(
  parameter int          H_OFFSET    = 40,
  parameter logic [7:0]  FG_LUMA     = 8'hFF,
  parameter logic [7:0]  BG_LUMA     = 8'h00,
  parameter logic [7:0]  BORDER_LUMA = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_clk_en,
  input  logic        video_active,
  input  logic        vsync_n,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  luma,
  output logic        in_vblank,
  output logic        frame_start
);
  logic [7:0]  mem [0:2399];
  logic [9:0]  x_q, x_d, y_q, y_d, hx;
  logic [11:0] addr_q, addr_d, r12;
  logic [2:0]  bit_q, bit_d;
  logic        win, win_q, win_d, act_q, act_d;
  logic        va_q, vs_q, p0_q, p1_q;
  logic [7:0]  vdat_q, crd_q, luma_q, luma_d;
  logic        rd_ok_q, rd_ok_d, vb_q, vb_d, fs_q, fs_d;

  always_comb begin
    hx      = x_q - 10'(H_OFFSET);
    win     = x_q >= 10'(H_OFFSET) && hx < 10'd640 && y_q < 10'd480;
    r12     = {4'd0, y_q[9:2]};
    x_d     = !video_active ? 10'd0 : pixel_clk_en ? x_q + 10'd1 : x_q;
    y_d     = !vsync_n ? 10'd0 : (va_q && !video_active && y_q != 10'h3FF) ? y_q + 10'd1 : y_q;
    // out-of-window fetches are parked on address 0 so the RAM index stays in range
    addr_d  = !pixel_clk_en ? addr_q : win ? (r12 << 4) + (r12 << 2) + {7'd0, hx[9:5]} : 12'd0;
    bit_d   = pixel_clk_en ? ~hx[4:2] : bit_q;
    win_d   = pixel_clk_en ? win : win_q;
    act_d   = pixel_clk_en ? video_active : act_q;
    luma_d  = !p1_q ? luma_q : !act_q ? BG_LUMA : !win_q ? BORDER_LUMA :
              vdat_q[bit_q] ? FG_LUMA : BG_LUMA;
    rd_ok_d = cpu_re ? cpu_addr < 12'd2400 : rd_ok_q;
    vb_d    = y_d >= 10'd480 || !vsync_n;
    fs_d    = vs_q && !vsync_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      va_q    <= 1'b0;
      vs_q    <= 1'b0;
      addr_q  <= '0;
      bit_q   <= '0;
      win_q   <= 1'b0;
      act_q   <= 1'b0;
      p0_q    <= 1'b0;
      p1_q    <= 1'b0;
      luma_q  <= BG_LUMA;
      rd_ok_q <= 1'b0;
      vb_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      va_q    <= video_active;
      vs_q    <= vsync_n;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      win_q   <= win_d;
      act_q   <= act_d;
      p0_q    <= pixel_clk_en;
      p1_q    <= p0_q;
      luma_q  <= luma_d;
      rd_ok_q <= rd_ok_d;
      vb_q    <= vb_d;
      fs_q    <= fs_d;
    end
  end

  // read-before-write on both ports: a same-clk write is seen from the next clk
  always_ff @(posedge clk) begin
    if (cpu_we && cpu_addr < 12'd2400) mem[cpu_addr] <= cpu_wdata;
    vdat_q <= mem[addr_q];
    if (cpu_re) crd_q <= mem[cpu_addr < 12'd2400 ? cpu_addr : 12'd0];
  end

  assign cpu_rdata   = rd_ok_q ? crd_q : 8'h00;
  assign luma        = luma_q;
  assign in_vblank   = vb_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_video_bitmap_gen.sv
// tb_video_bitmap_gen: drives pixel/line/vsync strobes and CPU traffic, checks
// luma against a screen-coordinate model of the bitmap.
module tb_video_bitmap_gen;
  localparam logic [7:0] FG = 8'hFF, BG = 8'h00, BORDER = 8'h40;
  logic clk = 0, reset = 1, pixel_clk_en = 0, video_active = 0, vsync_n = 1;
  logic cpu_we = 0, cpu_re = 0;
  logic [11:0] cpu_addr = 0;
  logic [7:0] cpu_wdata = 0, cpu_rdata, luma;
  logic in_vblank, frame_start;
  logic [7:0] bm [0:2399];
  int n_chk = 0, n_fail = 0, mx = 0, my = 0;
  bit mva = 0;

  video_bitmap_gen #(.H_OFFSET(40), .FG_LUMA(FG), .BG_LUMA(BG), .BORDER_LUMA(BORDER)) dut (
    .clk(clk), .reset(reset), .pixel_clk_en(pixel_clk_en), .video_active(video_active),
    .vsync_n(vsync_n), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .luma(luma), .in_vblank(in_vblank),
    .frame_start(frame_start));

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_luma(int x, int y, bit act);
    int col;
    logic [7:0] b;
    if (!act) return BG;
    if (x < 40 || x >= 680 || y >= 480) return BORDER;
    col = (x - 40) / 4;
    b = bm[(y / 4) * 20 + col / 8];
    return b[7 - col % 8] ? FG : BG;
  endfunction

  task automatic cpu_write(input int a, input logic [7:0] d);
    cpu_we = 1; cpu_addr = 12'(a); cpu_wdata = d;
    @(posedge clk); #1;
    cpu_we = 0;
    if (a < 2400) bm[a] = d;
  endtask

  task automatic cpu_read(input int a, input logic [7:0] e, input string nm);
    cpu_re = 1; cpu_addr = 12'(a);
    @(posedge clk); #1;
    cpu_re = 0;
    n_chk++;
    if (cpu_rdata !== e) begin
      n_fail++;
      $display("FAIL %s addr=%0d got %h expected %h", nm, a, cpu_rdata, e);
    end
  endtask

  // one pixel: strobe, optional CPU write on the fetch clk, luma checked 2 clks later
  task automatic px(input bit act, input bit coll = 0, input int ca = 0, input logic [7:0] cd = 0);
    logic [7:0] e;
    e = exp_luma(mx, my, act);
    pixel_clk_en = 1; video_active = act;
    @(posedge clk); #1;
    pixel_clk_en = 0;
    if (coll) begin cpu_we = 1; cpu_addr = 12'(ca); cpu_wdata = cd; end
    @(posedge clk); #1;
    cpu_we = 0;
    if (coll) bm[ca] = cd;
    @(posedge clk); #1;
    n_chk++;
    if (luma !== e) begin
      n_fail++;
      $display("FAIL luma x=%0d y=%0d act=%0b got %h expected %h", mx, my, act, luma, e);
    end
    if (act) mx++;
    else begin
      mx = 0;
      if (mva && my < 1023) my++;
    end
    mva = act;
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) px(1);
    px(0);
  endtask

  task automatic vsync();
    int pulses;
    pulses = 0;
    video_active = 0; vsync_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pulses += int'(frame_start);
    end
    n_chk++;
    if (in_vblank !== 1'b1) begin n_fail++; $display("FAIL vblank_in_vsync got %b expected 1", in_vblank); end
    vsync_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      pulses += int'(frame_start);
    end
    n_chk++;
    if (pulses != 1) begin n_fail++; $display("FAIL frame_start_pulses got %0d expected 1", pulses); end
    mx = 0; my = 0; mva = 0;
    n_chk++;
    if (in_vblank !== 1'b0) begin n_fail++; $display("FAIL vblank_after_vsync got %b expected 0", in_vblank); end
  endtask

  task automatic check_reset_outputs(input string nm);
    n_chk++;
    if (luma !== BG || in_vblank !== 1'b1 || frame_start !== 1'b0 || cpu_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL %s luma=%h vblank=%b fs=%b rdata=%h expected 00/1/0/00",
               nm, luma, in_vblank, frame_start, cpu_rdata);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    reset = 0;
    for (int a = 0; a < 2400; a++) cpu_write(a, 8'h00);
  endtask

  task automatic test_cpu();
    cpu_write(0, 8'hA5);
    cpu_read(0, 8'hA5, "rd_addr0");
    @(posedge clk); #1;
    n_chk++;
    if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold got %h expected a5", cpu_rdata); end
    cpu_read(2400, 8'h00, "rd_oob");
    cpu_write(2399, 8'h5A);
    cpu_write(2400, 8'h77);
    cpu_read(2399, 8'h5A, "wr_oob_2399");
    cpu_read(0, 8'hA5, "wr_oob_0");
    cpu_re = 1; cpu_we = 1; cpu_addr = 0; cpu_wdata = 8'h3C;
    @(posedge clk); #1;
    cpu_re = 0; cpu_we = 0; bm[0] = 8'h3C;
    n_chk++;
    if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL rw_same_clk got %h expected a5", cpu_rdata); end
    cpu_read(0, 8'h3C, "rw_new_data");
    for (int i = 0; i < 8; i++) begin
      int a;
      logic [7:0] d;
      a = $urandom_range(1, 2398);
      d = 8'($urandom);
      cpu_write(a, d);
      cpu_read(a, d, "rd_random");
    end
    for (int a = 0; a < 2400; a++) if (bm[a] != 8'h00) cpu_write(a, 8'h00);
  endtask

  task automatic test_pixel_map();
    cpu_write(0, 8'h80);
    vsync();
    for (int l = 0; l < 5; l++) line(700);
  endtask

  task automatic test_last_cell();
    cpu_write(2399, 8'h01);
    while (my < 476) line(1);
    for (int l = 0; l < 3; l++) line(700);
    for (int i = 0; i < 700; i++) px(1);
    n_chk++;
    if (in_vblank !== 1'b0) begin n_fail++; $display("FAIL vblank_y479 got %b expected 0", in_vblank); end
    px(0);
    n_chk++;
    if (in_vblank !== 1'b1) begin n_fail++; $display("FAIL vblank_y480 got %b expected 1", in_vblank); end
    line(700);
  endtask

  task automatic test_collision();
    vsync();
    while (my < 4) line(1);
    for (int i = 0; i < 40; i++) px(1);
    px(1, 1, 20, 8'hFF);
    for (int i = 0; i < 8; i++) px(1);
    px(0);
  endtask

  task automatic test_random();
    for (int a = 200; a < 360; a++) cpu_write(a, 8'($urandom));
    vsync();
    while (my < 40) line(1);
    for (int l = 0; l < 8; l++) line($urandom_range(41, 700));
  endtask

  task automatic test_reset_midline();
    vsync();
    for (int i = 0; i < 42; i++) px(1);
    cpu_read(0, 8'h80, "rd_before_reset");
    #2 reset = 1;
    #1 check_reset_outputs("reset_async");
    video_active = 0;
    @(posedge clk); #1;
    check_reset_outputs("reset_held");
    reset = 0;
    mx = 0; my = 0; mva = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (luma !== BG) begin n_fail++; $display("FAIL luma_after_reset got %h expected %h", luma, BG); end
    end
    vsync();
    line(700);
  endtask

  initial begin
    for (int a = 0; a < 2400; a++) bm[a] = 8'h00;
    test_reset();
    test_cpu();
    test_pixel_map();
    test_last_cell();
    test_collision();
    test_random();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
